// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and helpers for the LED/button controller
//
// Purpose : LED mode encodings, register addresses, register field offsets
//           and a counter-width helper shared by led_button_ctrl and
//           button_debounce.
// Ports   : none (package)
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ON     = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BUTTON = 2'd3
  } led_mode_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_PWM    = 2'd2;

  // CTRL: two 2-bit mode fields, LED0 in [1:0], LED1 in [3:2]
  localparam int CTRL_LED0_LSB = 0;
  localparam int CTRL_BITS     = 4;

  // STATUS: debounced levels in [1:0], sticky press flags in [3:2]
  localparam int STATUS_LEVEL_LSB = 0;
  localparam int STATUS_PRESS_LSB = 2;

  localparam logic [7:0] PWM_DUTY_RESET = 8'hFF;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_button_ctrl_if.sv
// rtl/led_button_ctrl_if.sv - CPU data-bus interface of the LED/button controller
//
// Purpose : groups the Hack CPU register bus.
// Signals : load    - write strobe, sampled on clk
//           address - register select (2 bits)
//           in      - write data (16 bits)
//           out     - read data, combinational from the addressed register
// Modports: master (CPU side), slave (controller side)
interface led_button_ctrl_if;
  logic        load;
  logic [1:0]  address;
  logic [15:0] in;
  logic [15:0] out;

  modport master (output load, output address, output in, input out);
  modport slave  (input load, input address, input in, output out);
endinterface

// File: rtl/led_button_ctrl_debounce.sv
// rtl/led_button_ctrl_debounce.sv - two-flop synchroniser plus debounce counter, one button
//
// Purpose : accepts a new button level only after the synchronised input has
//           differed from the accepted level for DEBOUNCE_CYCLES consecutive
//           cycles; raw edge to stable change is DEBOUNCE_CYCLES+2 cycles.
// Ports   : clk    - clock
//           reset  - synchronous, active-high
//           raw    - asynchronous button input, active-high
//           stable - debounced level
//           press  - one-cycle pulse coincident with a stable 0->1 change
module button_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
          press  <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // any agreement restarts the qualification window
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_button_ctrl.sv
// rtl/led_button_ctrl.sv - memory-mapped controller for two LEDs and two push-buttons
//
// Purpose : debounces the buttons, keeps sticky press flags, and drives each
//           LED from a per-LED mode (off / on / blink / follow button).
//           Optional macro LED_PWM_EN adds a duty register at address 2 that
//           gates mode 1 and the on-phase of mode 2.
// Ports   : clk   - clock, all logic on rising edge
//           reset - synchronous, active-high
//           bus   - CPU register bus (led_button_ctrl_if.slave)
//           but   - raw asynchronous buttons [1:0], active-high
//           led   - registered LED drive [1:0], active-high
module led_button_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLINK_DIV       = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  led_button_ctrl_if.slave bus,
  input  logic [1:0]       but,
  output logic [1:0]       led
);

  localparam int BW = cnt_width(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [1:0]           stable;
  logic [1:0]           press;
  logic [CTRL_BITS-1:0] ctrl;
  logic [1:0]           flags;
  logic [BW-1:0]        presc;
  logic                 phase;
  logic                 gate;
  logic                 wr_ctrl;
  logic                 wr_status;
  logic                 unused_in;

  for (genvar i = 0; i < 2; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .raw    (but[i]),
      .stable (stable[i]),
      .press  (press[i])
    );
  end

  assign wr_ctrl   = bus.load && (bus.address == ADDR_CTRL);
  assign wr_status = bus.load && (bus.address == ADDR_STATUS);
  assign unused_in = ^bus.in[15:4];

`ifdef LED_PWM_EN
  logic [7:0] duty;
  logic [7:0] pwmcnt;
  logic       wr_pwm;

  assign wr_pwm = bus.load && (bus.address == ADDR_PWM);

  always_ff @(posedge clk) begin
    if (reset) begin
      duty   <= PWM_DUTY_RESET;
      pwmcnt <= '0;
    end else begin
      pwmcnt <= pwmcnt + 8'd1;
      if (wr_pwm) duty <= bus.in[7:0];
    end
  end

  // duty 0 never lights; duty 255 lights 255 of every 256 cycles
  assign gate = (pwmcnt < duty);
`else
  assign gate = 1'b1;
`endif

  function automatic logic led_drive(input led_mode_e mode, input logic ph,
                                     input logic g, input logic st);
    case (mode)
      MODE_OFF:    return 1'b0;
      MODE_ON:     return g;
      MODE_BLINK:  return ph & g;
      MODE_BUTTON: return st;
      default:     return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl  <= '0;
      flags <= '0;
      presc <= '0;
      phase <= 1'b0;
      led   <= '0;
    end else begin
      // free-running: CTRL writes never disturb the blink cadence
      if (presc == BLINK_LAST) begin
        presc <= '0;
        phase <= ~phase;
      end else begin
        presc <= presc + 1'b1;
      end

      if (wr_ctrl) ctrl <= bus.in[CTRL_LED0_LSB +: CTRL_BITS];

      // W1C clear first, then OR in new presses so a same-cycle set wins
      flags <= (flags & ~(wr_status ? bus.in[STATUS_PRESS_LSB +: 2] : 2'b00)) | press;

      for (int i = 0; i < 2; i++) begin
        led[i] <= led_drive(led_mode_e'(ctrl[2*i +: 2]), phase, gate, stable[i]);
      end
    end
  end

  always_comb begin
    bus.out = '0;
    case (bus.address)
      ADDR_CTRL:   bus.out[CTRL_BITS-1:0] = ctrl;
      ADDR_STATUS: begin
        bus.out[STATUS_LEVEL_LSB +: 2] = stable;
        bus.out[STATUS_PRESS_LSB +: 2] = flags;
      end
`ifdef LED_PWM_EN
      ADDR_PWM:    bus.out[7:0] = duty;
`endif
      default:     bus.out = '0;
    endcase
  end

endmodule

// File: tb/tb_led_button_ctrl.sv
// tb/tb_led_button_ctrl.sv - self-checking bench for led_button_ctrl
module tb_led_button_ctrl;

  localparam int D = 4;
  localparam int B = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] but;
  logic [1:0] led;

  led_button_ctrl_if bus ();

  led_button_ctrl #(.DEBOUNCE_CYCLES(D), .BLINK_DIV(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .but   (but),
    .led   (led)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [3:0]  m_ctrl;
  logic [7:0]  m_duty;
  logic [1:0]  m_stable;
  logic [1:0]  m_flags;
  logic [1:0]  m_rose;
  logic [1:0]  m_p0;
  logic [1:0]  m_p1;
  logic [1:0]  m_led;
  int          m_k;
  logic [1:0]  hist[$];

  always @(posedge clk) begin : model
    logic [1:0] n_led;
    logic [1:0] clr;
    logic [1:0] rose_now;
    logic       ph;
    logic       g;
    logic       all_diff;
    if (reset) begin
      m_ctrl = '0; m_duty = 8'hFF; m_stable = '0; m_flags = '0; m_rose = '0;
      m_p0 = '0; m_p1 = '0; m_led = '0; m_k = 0;
      hist.delete();
    end else begin
      ph = ((m_k / B) % 2) == 1;
`ifdef LED_PWM_EN
      g = (m_k % 256) < int'(m_duty);
`else
      g = 1'b1;
`endif
      for (int i = 0; i < 2; i++) begin
        case (m_ctrl[2*i +: 2])
          2'd0: n_led[i] = 1'b0;
          2'd1: n_led[i] = g;
          2'd2: n_led[i] = ph & g;
          default: n_led[i] = m_stable[i];
        endcase
      end
      clr = (bus.load && bus.address == 2'd1) ? bus.in[3:2] : 2'b00;
      m_flags = (m_flags & ~clr) | m_rose;
      // accept a level once the last D synchronised samples all disagree
      hist.push_back(m_p1);
      if (hist.size() > D) void'(hist.pop_front());
      rose_now = '0;
      for (int i = 0; i < 2; i++) begin
        if (hist.size() == D) begin
          all_diff = 1'b1;
          foreach (hist[j]) if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[i] = ~m_stable[i];
            rose_now[i] = m_stable[i];
          end
        end
      end
      m_rose = rose_now;
      m_p1 = m_p0;
      m_p0 = but;
      if (bus.load && bus.address == 2'd0) m_ctrl = bus.in[3:0];
`ifdef LED_PWM_EN
      if (bus.load && bus.address == 2'd2) m_duty = bus.in[7:0];
`endif
      m_led = n_led;
      m_k++;
    end
  end

  function automatic logic [15:0] model_out(input logic [1:0] a);
    case (a)
      2'd0: return {12'h000, m_ctrl};
      2'd1: return {12'h000, m_flags, m_stable};
`ifdef LED_PWM_EN
      2'd2: return {8'h00, m_duty};
`endif
      default: return 16'h0000;
    endcase
  endfunction

  // drive inputs away from the edge, clock once, return at the next negedge
  task automatic tick(input logic [1:0] b, input logic ld, input logic [1:0] a, input logic [15:0] d);
    but = b; bus.load = ld; bus.address = a; bus.in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] exp_o;
    reset = 1'b1;
    tick(2'b11, 1'b0, 2'd0, 16'h0000);
    tick(2'b11, 1'b0, 2'd0, 16'h0000);
    checks++;
    if (led !== 2'b00) begin errors++; $display("FAIL reset_led: got %b want 00", led); end
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1;
`ifdef LED_PWM_EN
      exp_o = (a == 2) ? 16'h00FF : 16'h0000;
`else
      exp_o = 16'h0000;
`endif
      checks++;
      if (bus.out !== exp_o) begin errors++; $display("FAIL reset_out addr=%0d: got %h want %h", a, bus.out, exp_o); end
    end
    reset = 1'b0;
    for (int t = 0; t < D + 4; t++) begin
      tick(2'b00, 1'b0, 2'd1, 16'h0000);
      checks++;
      if (bus.out !== 16'h0000) begin errors++; $display("FAIL reset_settle status: got %h want 0000", bus.out); end
    end
  endtask

  task automatic test_debounce();
    logic [15:0] exp_o;
    for (int i = 1; i <= 9; i++) begin
      tick(2'b01, 1'b0, 2'd1, 16'h0000);
      exp_o = {12'h000, 1'b0, (i >= 7), 1'b0, (i >= 6)};
      checks++;
      if (bus.out !== exp_o) begin errors++; $display("FAIL debounce_rise cyc=%0d: got %h want %h", i, bus.out, exp_o); end
      checks++;
      if (bus.out !== model_out(2'd1)) begin errors++; $display("FAIL debounce_model cyc=%0d: got %h want %h", i, bus.out, model_out(2'd1)); end
    end
    for (int i = 1; i <= 12; i++) begin
      tick((i <= 3) ? 2'b11 : 2'b01, 1'b0, 2'd1, 16'h0000);
      checks++;
      if (bus.out[3] !== 1'b0 || bus.out[1] !== 1'b0) begin errors++; $display("FAIL glitch_ignored cyc=%0d: got %h want bits1,3 = 0", i, bus.out); end
    end
  endtask

  task automatic test_flag_clear();
    tick(2'b01, 1'b1, 2'd1, 16'h0004);
    tick(2'b01, 1'b0, 2'd1, 16'h0000);
    checks++;
    if (bus.out[2] !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %b want 0", bus.out[2]); end
    for (int i = 0; i < 10; i++) tick(2'b00, 1'b0, 2'd1, 16'h0000);
    checks++;
    if (bus.out !== 16'h0000) begin errors++; $display("FAIL release_status: got %h want 0000", bus.out); end
    for (int i = 1; i <= 6; i++) tick(2'b01, 1'b0, 2'd1, 16'h0000);
    tick(2'b01, 1'b1, 2'd1, 16'h0004);
    checks++;
    if (bus.out[2] !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got %b want 1", bus.out[2]); end
    checks++;
    if (bus.out !== model_out(2'd1)) begin errors++; $display("FAIL set_beats_clear_model: got %h want %h", bus.out, model_out(2'd1)); end
  endtask

  task automatic test_modes();
    logic prev;
    int   last_t;
    tick(2'b01, 1'b1, 2'd0, 16'h000E);
    last_t = -1;
    prev = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      tick(2'b01, 1'b0, 2'd0, 16'h0000);
      checks++;
      if (led !== m_led) begin errors++; $display("FAIL modes_led t=%0d: got %b want %b", t, led, m_led); end
`ifndef LED_PWM_EN
      if (t >= 2 && led[0] !== prev) begin
        if (last_t >= 0) begin
          checks++;
          if (t - last_t != B) begin errors++; $display("FAIL blink_period: got %0d want %0d", t - last_t, B); end
        end
        last_t = t;
      end
`endif
      prev = led[0];
    end
    for (int i = 1; i <= 9; i++) begin
      tick(2'b10, 1'b0, 2'd0, 16'h0000);
      checks++;
      if (led[1] !== (i >= 7)) begin errors++; $display("FAIL follow_button cyc=%0d: got %b want %b", i, led[1], (i >= 7)); end
      checks++;
      if (led !== m_led) begin errors++; $display("FAIL follow_model cyc=%0d: got %b want %b", i, led, m_led); end
    end
  endtask

  task automatic test_reserved();
    tick(2'b10, 1'b1, 2'd3, 16'hFFFF);
    tick(2'b10, 1'b1, 2'd0, 16'hFFFF);
    bus.load = 1'b0;
    bus.address = 2'd0; #1;
    checks++;
    if (bus.out !== 16'h000F) begin errors++; $display("FAIL ctrl_mask: got %h want 000F", bus.out); end
    bus.address = 2'd3; #1;
    checks++;
    if (bus.out !== 16'h0000) begin errors++; $display("FAIL addr3_reads0: got %h want 0000", bus.out); end
  endtask

  task automatic test_pwm();
    int hi;
`ifdef LED_PWM_EN
    tick(2'b00, 1'b1, 2'd0, 16'h0001);
    tick(2'b00, 1'b1, 2'd2, 16'h0040);
    tick(2'b00, 1'b0, 2'd2, 16'h0000);
    checks++;
    if (bus.out !== 16'h0040) begin errors++; $display("FAIL pwm_readback: got %h want 0040", bus.out); end
    hi = 0;
    for (int t = 0; t < 256; t++) begin
      tick(2'b00, 1'b0, 2'd2, 16'h0000);
      hi += int'(led[0]);
    end
    checks++;
    if (hi != 64) begin errors++; $display("FAIL pwm_duty64: got %0d high cycles want 64", hi); end
    tick(2'b00, 1'b1, 2'd2, 16'h0000);
    tick(2'b00, 1'b0, 2'd2, 16'h0000);
    hi = 0;
    for (int t = 0; t < 256; t++) begin
      tick(2'b00, 1'b0, 2'd2, 16'h0000);
      hi += int'(led[0]);
    end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL pwm_duty0: got %0d high cycles want 0", hi); end
`else
    tick(2'b00, 1'b1, 2'd0, 16'h0001);
    tick(2'b00, 1'b1, 2'd2, 16'h0040);
    hi = 0;
    for (int t = 0; t < 20; t++) begin
      tick(2'b00, 1'b0, 2'd2, 16'h0000);
      hi += int'(led[0]);
      checks++;
      if (bus.out !== 16'h0000) begin errors++; $display("FAIL pwm_absent_reads0: got %h want 0000", bus.out); end
    end
    checks++;
    if (hi != 20) begin errors++; $display("FAIL mode_on_solid: got %0d of 20 high", hi); end
`endif
  endtask

  task automatic test_random();
    logic [1:0] b;
    int         hold;
    logic       ld;
    logic [1:0] a;
    logic [15:0] d;
    hold = 0;
    b = 2'b00;
    for (int t = 0; t < 1500; t++) begin
      if (hold == 0) begin
        b = 2'($urandom);
        hold = $urandom_range(1, 2 * D + 2);
      end
      hold--;
      ld = ($urandom_range(0, 5) == 0);
      a = 2'($urandom);
      d = 16'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick(b, ld, a, d);
      reset = 1'b0;
      checks++;
      if (led !== m_led) begin errors++; $display("FAIL random_led t=%0d: got %b want %b", t, led, m_led); end
      checks++;
      if (bus.out !== model_out(bus.address)) begin errors++; $display("FAIL random_out t=%0d addr=%0d: got %h want %h", t, bus.address, bus.out, model_out(bus.address)); end
    end
  endtask

  initial begin
    reset = 1'b1;
    but = 2'b11;
    bus.load = 1'b0;
    bus.address = 2'd0;
    bus.in = 16'h0000;
    test_reset();
    test_debounce();
    test_flag_clear();
    test_modes();
    test_reserved();
    test_pwm();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
